// File: rtl/mac_result_writer_if.sv
// Handshake and bus bundle for mac_result_writer.
//   start/count      : run launch pulse and result count (1..2**ADDR_W)
//   in_valid/ready   : valid/ready handshake carrying in_data (signed MAC result)
//   rd_en/addr/data  : registered read port into the result RAM
//   wr_ptr/busy/done : progress status; done is a one-cycle end-of-run pulse
//   sat              : sticky saturation flag for the current/last run
// Modports: master drives requests (host / upstream side), slave is the writer.
interface mac_result_writer_if #(
  parameter int unsigned IN_W   = 64,
  parameter int unsigned OUT_W  = 32,
  parameter int unsigned ADDR_W = 8
);
  logic              start;
  logic [ADDR_W:0]   count;
  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [OUT_W-1:0]  rd_data;
  logic [ADDR_W-1:0] wr_ptr;
  logic              busy;
  logic              done;
  logic              sat;

  modport master (
    output start, count, in_valid, in_data, rd_en, rd_addr,
    input  in_ready, rd_data, wr_ptr, busy, done, sat
  );

  modport slave (
    input  start, count, in_valid, in_data, rd_en, rd_addr,
    output in_ready, rd_data, wr_ptr, busy, done, sat
  );
endinterface

// File: rtl/mac_result_writer.sv
// mac_result_writer: accepts signed MAC results over valid/ready, rescales them by an
// arithmetic right shift, saturates to OUT_W bits and writes them in order into a result
// RAM. A registered read port (1-cycle latency, old data on same-address write) is
// available in every state.
// Ports:
//   clk_i  : rising-edge clock
//   rst_ni : synchronous active-low reset (RAM contents are kept)
//   bus    : mac_result_writer_if.slave (start/count, in_* handshake, rd_* port, status)
// Build option: define RESULT_RELU_EN to clamp negative shifted results to zero.
module mac_result_writer #(
  parameter int unsigned IN_W   = 64,
  parameter int unsigned OUT_W  = 32,
  parameter int unsigned SHIFT  = 0,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  mac_result_writer_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StAccept, StWrite, StDone} state_e;

  localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(DEPTH);
  // Saturation bounds of an OUT_W-bit signed word, expressed at IN_W width.
  localparam logic signed [IN_W-1:0] SatMax = {{(IN_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [IN_W-1:0] SatMin = {{(IN_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              sat_q, sat_d;
  logic [OUT_W-1:0]  word_q, word_d;
  logic              flag_q, flag_d;
  logic [OUT_W-1:0]  rd_data_q;

  logic [OUT_W-1:0]  mem_q [DEPTH];

  logic signed [IN_W-1:0] shifted;
  logic [OUT_W-1:0]       scaled_word;
  logic                   scaled_sat;
  logic                   count_ok;
  logic                   last;

  // Rescale and saturate the incoming result.
  always_comb begin
    shifted = $signed(bus.in_data) >>> SHIFT;
`ifdef RESULT_RELU_EN
    if (shifted[IN_W-1]) begin
      shifted = '0;
    end
`endif
    scaled_word = shifted[OUT_W-1:0];
    scaled_sat  = 1'b0;
    if (shifted > SatMax) begin
      scaled_word = SatMax[OUT_W-1:0];
      scaled_sat  = 1'b1;
    end else if (shifted < SatMin) begin
      scaled_word = SatMin[OUT_W-1:0];
      scaled_sat  = 1'b1;
    end
  end

  assign count_ok = (bus.count != '0) && (bus.count <= DepthCnt);
  assign last     = ({1'b0, wr_ptr_q} == (count_q - 1'b1));

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    sat_d    = sat_q;
    word_d   = word_q;
    flag_d   = flag_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start && count_ok) begin
          count_d  = bus.count;
          wr_ptr_d = '0;
          sat_d    = 1'b0;
          state_d  = StAccept;
        end
      end
      StAccept: begin
        if (bus.in_valid) begin
          word_d  = scaled_word;
          flag_d  = scaled_sat;
          state_d = StWrite;
        end
      end
      StWrite: begin
        sat_d = sat_q | flag_q;
        if (last) begin
          state_d = StDone;
        end else begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          state_d  = StAccept;
        end
      end
      StDone: begin
        wr_ptr_d = '0;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      count_q  <= '0;
      sat_q    <= 1'b0;
      word_q   <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      sat_q    <= sat_d;
      word_q   <= word_d;
      flag_q   <= flag_d;
    end
  end

  // Result RAM: never cleared; a write during reset is suppressed so an aborted run
  // leaves only completed entries behind.
  always_ff @(posedge clk_i) begin
    if (rst_ni && (state_q == StWrite)) begin
      mem_q[wr_ptr_q] <= word_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_data_q <= '0;
    end else if (bus.rd_en) begin
      rd_data_q <= mem_q[bus.rd_addr];
    end
  end

  assign bus.in_ready = (state_q == StAccept);
  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = (state_q == StDone);
  assign bus.wr_ptr   = wr_ptr_q;
  assign bus.sat      = sat_q;
  assign bus.rd_data  = rd_data_q;

endmodule

// File: tb/tb_mac_result_writer.sv
// Self-checking bench for mac_result_writer. Read responses are scoreboarded: each read
// pushes its expected word and a monitor compares rd_data the cycle after rd_en.
// A second instance with SHIFT=8 shares all stimulus.
module tb_mac_result_writer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mac_result_writer_if #(.IN_W(64), .OUT_W(32), .ADDR_W(8)) ifc ();
  mac_result_writer_if #(.IN_W(64), .OUT_W(32), .ADDR_W(8)) ifc8 ();

  mac_result_writer #(.IN_W(64), .OUT_W(32), .SHIFT(0), .DEPTH(256), .ADDR_W(8)) u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (ifc.slave)
  );

  mac_result_writer #(.IN_W(64), .OUT_W(32), .SHIFT(8), .DEPTH(256), .ADDR_W(8)) u_dut8 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (ifc8.slave)
  );

  assign ifc8.start    = ifc.start;
  assign ifc8.count    = ifc.count;
  assign ifc8.in_valid = ifc.in_valid;
  assign ifc8.in_data  = ifc.in_data;
  assign ifc8.rd_en    = ifc.rd_en;
  assign ifc8.rd_addr  = ifc.rd_addr;

  int checks = 0;
  int failures = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  logic rd_pend = 1'b0;
  logic [31:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Event monitors sampled at the active edge (inputs change on negedge only).
  initial forever begin
    @(posedge clk);
    if (ifc.in_valid && ifc.in_ready) hs_cnt++;
    if (ifc.done) done_cnt++;
    rd_pend = ifc.rd_en;
  end

  // Scoreboard monitor for the read port.
  initial forever begin
    @(negedge clk);
    if (rd_pend) begin
      if (exp_q.size() == 0) begin
        check("rd_unexpected", 64'(ifc.rd_data), 64'hDEAD_0000);
      end else begin
        check("rd_data", 64'(ifc.rd_data), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(input int c);
    ifc.start = 1'b1;
    ifc.count = 9'(c);
    tick(1);
    ifc.start = 1'b0;
  endtask

  task automatic send(input logic [63:0] val, input int gap, input int exp_ptr);
    bit ok = 0;
    ifc.in_valid = 1'b0;
    tick(gap);
    ifc.in_valid = 1'b1;
    ifc.in_data  = val;
    for (int i = 0; i < 20; i++) begin
      if (ifc.in_ready) begin
        ok = 1;
        break;
      end
      tick(1);
    end
    check("send_ready_timeout", 64'(ok), 64'd1);
    tick(1);
    ifc.in_valid = 1'b0;
    check("ready_low_in_write", 64'(ifc.in_ready), 64'd0);
    check("wr_ptr_in_write", 64'(ifc.wr_ptr), 64'(exp_ptr));
  endtask

  task automatic rd(input int addr, input logic [31:0] exp);
    exp_q.push_back(exp);
    ifc.rd_en   = 1'b1;
    ifc.rd_addr = 8'(addr);
    tick(1);
    ifc.rd_en = 1'b0;
  endtask

  initial begin
    int d0;
    int h0;
    logic [31:0] exp_neg;
    ifc.start = 0; ifc.count = 0; ifc.in_valid = 0; ifc.in_data = 0;
    ifc.rd_en = 0; ifc.rd_addr = 0;

    // Reset
    tick(3);
    check("rst_in_ready", 64'(ifc.in_ready), 0);
    check("rst_busy", 64'(ifc.busy), 0);
    check("rst_done", 64'(ifc.done), 0);
    check("rst_sat", 64'(ifc.sat), 0);
    check("rst_wr_ptr", 64'(ifc.wr_ptr), 0);
    check("rst_rd_data", 64'(ifc.rd_data), 0);
    rst_n = 1'b1;
    tick(1);

    // Basic run
    d0 = done_cnt;
    do_start(4);
    check("basic_busy", 64'(ifc.busy), 1);
    check("basic_ready", 64'(ifc.in_ready), 1);
    for (int i = 0; i < 4; i++) send(64'(i + 1), 0, i);
    tick(1);
    check("basic_done_pulse", 64'(ifc.done), 1);
    tick(1);
    check("basic_done_low", 64'(ifc.done), 0);
    check("basic_idle", 64'(ifc.busy), 0);
    check("basic_wr_ptr0", 64'(ifc.wr_ptr), 0);
    check("basic_done_cnt", 64'(done_cnt - d0), 1);
    rd(2, 32'd3);
    for (int i = 0; i < 4; i++) rd(i, 32'(i + 1));

    // Saturation
`ifdef RESULT_RELU_EN
    exp_neg = 32'h0000_0000;
`else
    exp_neg = 32'h8000_0000;
`endif
    do_start(2);
    send(64'h0000_0001_0000_0000, 0, 0);
    send(64'hFFFF_FF00_0000_0000, 0, 1);
    tick(3);
    check("sat_sticky", 64'(ifc.sat), 1);
    rd(0, 32'h7FFF_FFFF);
    rd(1, exp_neg);

    // Handshake gaps, start while busy, invalid counts
    d0 = done_cnt;
    h0 = hs_cnt;
    do_start(3);
    check("sat_cleared_on_start", 64'(ifc.sat), 0);
    send(64'd10, 2, 0);
    ifc.start = 1'b1;
    ifc.count = 9'd1;
    tick(1);
    ifc.start = 1'b0;
    check("start_busy_ignored", 64'(ifc.busy), 1);
    send(64'd11, 0, 1);
    send(64'd12, 3, 2);
    tick(1);
    check("gap_done_pulse", 64'(ifc.done), 1);
    tick(2);
    check("gap_handshakes", 64'(hs_cnt - h0), 3);
    check("gap_done_cnt", 64'(done_cnt - d0), 1);
    rd(0, 32'd10);
    rd(1, 32'd11);
    rd(2, 32'd12);
    rd(3, 32'd4);
    d0 = done_cnt;
    do_start(0);
    check("count0_idle", 64'(ifc.busy), 0);
    do_start(257);
    check("count257_idle", 64'(ifc.busy), 0);
    tick(3);
    check("bad_count_no_done", 64'(done_cnt - d0), 0);

    // Reset mid-run
    d0 = done_cnt;
    do_start(4);
    send(64'd20, 0, 0);
    send(64'd21, 0, 1);
    tick(1);
    rst_n = 1'b0;
    tick(1);
    check("midrst_busy", 64'(ifc.busy), 0);
    check("midrst_wr_ptr", 64'(ifc.wr_ptr), 0);
    check("midrst_ready", 64'(ifc.in_ready), 0);
    rst_n = 1'b1;
    tick(3);
    check("midrst_no_done", 64'(done_cnt - d0), 0);
    do_start(1);
    send(64'd7, 0, 0);
    tick(1);
    check("single_done", 64'(ifc.done), 1);
    tick(1);
    rd(0, 32'd7);
    rd(1, 32'd21);
    rd(2, 32'd12);

    // SHIFT=8 rescale (shared stimulus, second instance)
    do_start(1);
    send(64'h0000_0000_0012_3400, 0, 0);
    tick(2);
    rd(0, 32'h0012_3400);
    check("shift8_word", 64'(ifc8.rd_data), 64'h1234);

    // Negative input
`ifdef RESULT_RELU_EN
    exp_neg = 32'h0000_0000;
`else
    exp_neg = 32'hFFFF_FFFB;
`endif
    do_start(1);
    send(-64'sd5, 0, 0);
    tick(2);
    rd(0, exp_neg);
    check("neg_sat", 64'(ifc.sat), 0);

    tick(3);
    check("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
